// File: rtl/alu_ctrl.sv
// Command FIFO feeding a multi-cycle ALU: pops {opcode, opA, opB} entries in order and holds each result for a ready/valid consumer.
// Optional macro ALU_CTRL_CNT_EN adds the op_count handshake counter output.
module alu_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opA,
  input  logic [7:0]  in_opB,
  input  logic        in_opcode,
  output logic [7:0]  alu_opA,
  output logic [7:0]  alu_opB,
  output logic        alu_opcode,
  input  logic [15:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic        busy
`ifdef ALU_CTRL_CNT_EN
  ,
  output logic [7:0]  op_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int unsigned EW = 17;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   lat_cnt;
  logic [EW-1:0]   head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign busy     = (state == WAIT);

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem[wr_ptr[AW-1:0]] <= {in_opcode, in_opA, in_opB};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lat_cnt    <= '0;
      out_valid  <= 1'b0;
      out_res    <= '0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        alu_opcode <= head[16];
        alu_opA    <= head[15:8];
        alu_opB    <= head[7:0];
        lat_cnt    <= CW'(ALU_LAT - 1);
      end
      case (state)
        IDLE: begin
          if (pop) state <= WAIT;
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CW'(1);
          end else begin
            out_res   <= alu_res;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= pop ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CTRL_CNT_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl (DEPTH=4, ALU_LAT=1) with a behavioural add/multiply ALU.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opA;
  logic [7:0]  in_opB;
  logic        in_opcode;
  logic [7:0]  alu_opA;
  logic [7:0]  alu_opB;
  logic        alu_opcode;
  logic [15:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        busy;
`ifdef ALU_CTRL_CNT_EN
  logic [7:0]  op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  // Fill/backpressure commands {op, A, B} and their hand-computed results
  logic [16:0] bp_cmd [5] = '{{1'b0, 8'h05, 8'h06}, {1'b1, 8'h07, 8'h08}, {1'b0, 8'h7F, 8'h01},
                              {1'b1, 8'h20, 8'h08}, {1'b0, 8'hAA, 8'h55}};
  logic [15:0] bp_exp [5] = '{16'h000B, 16'h0038, 16'h0080, 16'h0100, 16'h00FF};
  logic [16:0] bb_cmd [8] = '{{1'b0, 8'h01, 8'h02}, {1'b1, 8'h03, 8'h04}, {1'b0, 8'h10, 8'h20},
                              {1'b1, 8'h10, 8'h10}, {1'b0, 8'hFF, 8'h01}, {1'b1, 8'h0F, 8'h11},
                              {1'b0, 8'hFF, 8'hFF}, {1'b1, 8'hFE, 8'h03}};
  logic [15:0] bb_exp [8] = '{16'h0003, 16'h000C, 16'h0030, 16'h0100,
                              16'h0100, 16'h00FF, 16'h01FE, 16'h02FA};

  always #5 clk = ~clk;

  assign alu_res = alu_opcode ? (16'(alu_opA) * 16'(alu_opB)) : (16'(alu_opA) + 16'(alu_opB));

  alu_ctrl #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opA(in_opA), .in_opB(in_opB), .in_opcode(in_opcode),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy)
`ifdef ALU_CTRL_CNT_EN
    , .op_count(op_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [16:0] cmd);
    in_valid  = 1'b1;
    in_opcode = cmd[16];
    in_opA    = cmd[15:8];
    in_opB    = cmd[7:0];
  endtask

  // Consumes n results (out_ready assumed high), checking order and optionally the 2-cycle spacing
  task automatic collect(input int n, input int budget, input bit gap_chk);
    int got  = 0;
    int last = 0;
    logic [15:0] exp;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("result", 32'(out_res), 32'(exp));
        if (gap_chk && got > 0) check("gap", 32'(c - last), 32'd2);
        last = c;
        got++;
      end
      step();
    end
    check("result_count", 32'(got), 32'(n));
  endtask

  task automatic push_seq(input logic [16:0] cmd, input int n);
    int sent = 0;
    logic rdy;
    for (int t = 0; t < 4000 && sent < n; t++) begin
      drive(cmd);
      rdy = in_ready;
      step();
      if (rdy) sent++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int extra;
    logic rdy;
    nrst = 1'b0; in_valid = 1'b0; in_opcode = 1'b0; in_opA = '0; in_opB = '0; out_ready = 1'b0;
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_res",   32'(out_res),   32'd0);
    check("rst_alu_ops",   32'({alu_opcode, alu_opA, alu_opB}), 32'd0);
    nrst = 1'b1;

    // Single add: valid two edges after the push edge
    out_ready = 1'b1;
    drive({1'b0, 8'h12, 8'h34});
    step();
    in_valid = 1'b0;
    check("add_not_yet", 32'(out_valid), 32'd0);
    step();
    check("add_busy",   32'(busy), 32'd1);
    check("add_alu_ops", 32'({alu_opcode, alu_opA, alu_opB}), 32'h01234);
    step();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_res",   32'(out_res),   32'h0046);
    step();
    check("add_consumed", 32'(out_valid), 32'd0);
    check("add_idle",     32'(busy),      32'd0);

    // Single multiply
    drive({1'b1, 8'hFF, 8'hFF});
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_res",   32'(out_res),   32'hFE01);
    step();

    // Fill under backpressure, then a rejected push into the full FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd1);
      drive(bp_cmd[i]);
      exp_q.push_back(bp_exp[i]);
      step();
    end
    drive({1'b1, 8'h02, 8'h02});
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_busy",  32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_hold_res",   32'(out_res),  32'h000B);
    out_ready = 1'b1;
    collect(5, 40, 1'b0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      step();
    end
    check("bp_no_extra", 32'(extra), 32'd0);

    // Back-to-back alternating add/multiply at full rate
    for (int i = 0; i < 8; i++) exp_q.push_back(bb_exp[i]);
    fork
      begin
        int sent = 0;
        for (int t = 0; t < 200 && sent < 8; t++) begin
          drive(bb_cmd[sent]);
          rdy = in_ready;
          step();
          if (rdy) sent++;
        end
        in_valid = 1'b0;
      end
      collect(8, 100, 1'b1);
    join

    // Reset during WAIT with three commands still queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive({1'b0, 8'(i + 1), 8'h10});
      if (i == 4) out_ready = 1'b1;
      step();
    end
    check("mid_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    drive({1'b1, 8'h09, 8'h09});
    step();
    in_valid = 1'b0;
    nrst = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_res",   32'(out_res),   32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) extra++;
      step();
    end
    check("mid_no_stale", 32'(extra), 32'd0);
    drive({1'b0, 8'hAA, 8'h55});
    exp_q.push_back(16'h00FF);
    step();
    in_valid = 1'b0;
    collect(1, 10, 1'b0);

`ifdef ALU_CTRL_CNT_EN
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    check("cnt_reset", 32'(op_count), 32'd0);
    for (int i = 0; i < 258; i++) exp_q.push_back(16'h0002);
    fork
      push_seq({1'b0, 8'h01, 8'h01}, 258);
      collect(258, 700, 1'b0);
    join
    check("cnt_wrap", 32'(op_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; a power of two, minimum 2.
REQ-002 Parameter ALU_LAT, default 1, cycles the ALU result is allowed to settle before capture; minimum 1.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port nrst  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  command present.
REQ-006 Port in_ready  output  1  command FIFO can accept.
REQ-007 Port in_opA  input  8  operand A.
REQ-008 Port in_opB  input  8  operand B.
REQ-009 Port in_opcode  input  1  0 = add, 1 = multiply.
REQ-010 Port alu_opA, alu_opB  output  8 each  registered operands driven to the downstream alu.
REQ-011 Port alu_opcode  output  1  registered opcode driven to the alu.
REQ-012 Port alu_res  input  16  combinational result returned by the alu.
REQ-013 Port out_valid  output  1  out_res holds an unconsumed result.
REQ-014 Port out_ready  input  1  consumer accepts the result.
REQ-015 Port out_res  output  16  captured result.
REQ-016 Port busy  output  1  high when the FSM is in WAIT.

Function
REQ-017 Command FIFO: 17-bit entries {opcode, opA, opB}, DEPTH entries, pointers one bit wider than log2(DEPTH), wrap to 0 after DEPTH-1.
REQ-018 in_ready = FIFO not full; push occurs on in_valid && in_ready; no bypass, so a full FIFO does not accept a push even when a pop occurs in the same cycle.
REQ-019 FSM states: IDLE, WAIT, HOLD.
REQ-020 IDLE, FIFO non-empty: pop the head, load alu_op* registers, set the latency counter to ALU_LAT-1, go to WAIT.
REQ-021 IDLE, FIFO empty: remain in IDLE.
REQ-022 WAIT, counter non-zero: decrement the counter.
REQ-023 WAIT, counter zero: capture alu_res into out_res, set out_valid, go to HOLD.
REQ-024 HOLD, out_ready high and FIFO non-empty: clear out_valid, pop and load as in REQ-020, go to WAIT.
REQ-025 HOLD, out_ready high and FIFO empty: clear out_valid, go to IDLE.
REQ-026 HOLD, out_ready low: hold out_res and out_valid stable.
REQ-027 Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE gives out_valid high after edge N+1+ALU_LAT.
REQ-028 alu_op* outputs are stable from the load edge through the capture edge, and hold their last value while in IDLE or HOLD.
REQ-029 Sustained throughput is one result per ALU_LAT+1 cycles when out_ready is held high.
REQ-030 Results emerge in push order; every accepted command produces exactly one result; no command is dropped or duplicated.

Reset
REQ-031 When nrst is low at a rising edge, the block SHALL apply: FSM to IDLE; FIFO pointers to 0 (empty, in_ready=1); out_valid=0; out_res=0; alu_opA=alu_opB=0; alu_opcode=0; latency counter=0; busy=0.
REQ-032 Reset asserted mid-operation discards FIFO contents and any in-flight result; no out_valid pulse follows reset.
REQ-033 A push presented in a reset cycle is ignored.

Configuration
REQ-034 Macro ALU_CTRL_CNT_EN defined: the block adds output op_count (8 bits), which resets to 0, increments on each out_valid && out_ready handshake, and wraps 255 to 0.
REQ-035 Macro ALU_CTRL_CNT_EN undefined: op_count and its counter are absent from the module; all other behaviour is identical.

Verification
REQ-036 Single add: after reset, push {0, 8'h12, 8'h34} with out_ready=1 -> out_valid after 2 edges (ALU_LAT=1) with out_res=16'h0046.
REQ-037 Single multiply: push {1, 8'hFF, 8'hFF} -> out_res=16'hFE01.
REQ-038 Fill and backpressure: out_ready=0, push 5 commands with DEPTH=4 -> first result held in HOLD, in_ready low after 4 more accepted; release out_ready -> all results appear in order with no loss.
REQ-039 Back-to-back: 8 alternating add/multiply commands with out_ready=1 -> one result every 2 cycles, values and order correct.
REQ-040 Reset mid-WAIT: assert nrst low during WAIT with 3 commands queued -> after reset out_valid=0, in_ready=1, and no stale result emerges.
REQ-041 With ALU_CTRL_CNT_EN: 258 completed handshakes -> op_count=2.
